// File: rtl/fix_parser_pkg.sv
// Shared types and defaults for the message location writer/reader pair.
package fix_parser_pkg;

    localparam int NUM_MESSAGE_DEF = 5;
    localparam int DATA_WIDTH_DEF  = 5;
    localparam int BYTE_WIDTH_DEF  = 8;

    typedef logic [NUM_MESSAGE_DEF-1:0] msg_idx_t;
    typedef logic [DATA_WIDTH_DEF-1:0]  buf_addr_t;

    // Reader FSM states:
    //   IDLE    | waiting for a pending message
    //   LOC_REQ | location table read issued
    //   LOC_CAP | start/end addresses captured
    //   FETCH   | buffer read issued for current byte
    //   LATCH   | buffer data captured into output register
    //   SEND    | byte presented, waiting for downstream accept
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOC_REQ = 3'd1,
        LOC_CAP = 3'd2,
        FETCH   = 3'd3,
        LATCH   = 3'd4,
        SEND    = 3'd5
    } loc_rd_state_e;

endpackage

// File: rtl/msg_byte_out_reg.sv
// Output byte register with sof/eof qualifiers; holds everything stable
// until the byte is accepted (or cleared by the FSM).
module msg_byte_out_reg #(
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic [BYTE_WIDTH-1:0] byte_i,
    input  logic                  sof_i,
    input  logic                  eof_i,
    output logic [BYTE_WIDTH-1:0] byte_o,
    output logic                  byte_valid_o,
    output logic                  sof_o,
    output logic                  eof_o
);

    logic [BYTE_WIDTH-1:0] byte_q;
    logic                  valid_q;
    logic                  sof_q;
    logic                  eof_q;

    // Load on capture, drop valid/markers on accept; byte value is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else if (load_i) begin
            byte_q  <= byte_i;
            valid_q <= 1'b1;
            sof_q   <= sof_i;
            eof_q   <= eof_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign sof_o        = sof_q;
    assign eof_o        = eof_q;

endmodule

// File: rtl/message_loc_reader.sv
// Reads completed messages: fetches start/end from the location table, then
// streams the bytes out of the message buffer with sof/eof markers.
// Optional LOC_READER_DROP_EN adds drop_i to abandon a message while in SEND.
module message_loc_reader
    import fix_parser_pkg::*;
#(
    parameter int NUM_MESSAGE = NUM_MESSAGE_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int BYTE_WIDTH  = BYTE_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MESSAGE-1:0] wr_count_i,
    output logic [NUM_MESSAGE-1:0] rd_count_o,
    output logic                   loc_rd_o,
    output logic [NUM_MESSAGE-1:0] loc_addr_o,
    input  logic [DATA_WIDTH-1:0]  loc_start_i,
    input  logic [DATA_WIDTH-1:0]  loc_end_i,
    output logic                   buf_rd_o,
    output logic [DATA_WIDTH-1:0]  buf_addr_o,
    input  logic [BYTE_WIDTH-1:0]  buf_data_i,
    output logic [BYTE_WIDTH-1:0]  byte_o,
    output logic                   byte_valid_o,
    input  logic                   byte_ready_i,
`ifdef LOC_READER_DROP_EN
    input  logic                   drop_i,
`endif
    output logic                   sof_o,
    output logic                   eof_o,
    output logic                   busy_o
);

    loc_rd_state_e          state_q;
    logic [NUM_MESSAGE-1:0] rd_count_q;
    logic [DATA_WIDTH-1:0]  ptr_q;
    logic [DATA_WIDTH-1:0]  end_q;
    logic                   first_q;
    logic                   loc_rd_q;
    logic                   buf_rd_q;
    logic                   busy_q;

    logic pending_d;
    logic drop_d;
    logic accept_d;
    logic load_d;
    logic clear_d;

`ifdef LOC_READER_DROP_EN
    assign drop_d = drop_i;
`else
    assign drop_d = 1'b0;
`endif

    assign pending_d = (rd_count_q != wr_count_i);
    assign accept_d  = (state_q == SEND) && byte_ready_i;
    assign load_d    = (state_q == LATCH);
    assign clear_d   = (state_q == SEND) && (byte_ready_i || drop_d);

    // Sequencer: location fetch, then fetch/latch/send per byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_count_q <= '0;
            ptr_q      <= '0;
            end_q      <= '0;
            first_q    <= 1'b0;
            loc_rd_q   <= 1'b0;
            buf_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            loc_rd_q <= 1'b0;
            buf_rd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pending_d) begin
                        state_q  <= LOC_REQ;
                        loc_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                LOC_REQ: state_q <= LOC_CAP;
                LOC_CAP: begin
                    ptr_q    <= loc_start_i;
                    end_q    <= loc_end_i;
                    first_q  <= 1'b1;
                    state_q  <= FETCH;
                    buf_rd_q <= 1'b1;
                end
                FETCH: state_q <= LATCH;
                LATCH: state_q <= SEND;
                SEND: begin
                    if (drop_d || (accept_d && eof_o)) begin
                        rd_count_q <= rd_count_q + 1'b1;
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                    end else if (accept_d) begin
                        ptr_q    <= ptr_q + 1'b1;
                        first_q  <= 1'b0;
                        state_q  <= FETCH;
                        buf_rd_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    msg_byte_out_reg #(
        .BYTE_WIDTH(BYTE_WIDTH)
    ) u_out (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_d),
        .clear_i      (clear_d),
        .byte_i       (buf_data_i),
        .sof_i        (first_q),
        .eof_i        (ptr_q == end_q),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .sof_o        (sof_o),
        .eof_o        (eof_o)
    );

    assign rd_count_o = rd_count_q;
    assign loc_rd_o   = loc_rd_q;
    assign loc_addr_o = rd_count_q;
    assign buf_rd_o   = buf_rd_q;
    assign buf_addr_o = ptr_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_message_loc_reader.sv
// Directed bench for message_loc_reader with table/buffer models.
module tb_message_loc_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] wr_count_i = '0;
    logic [4:0] rd_count_o;
    logic       loc_rd_o;
    logic [4:0] loc_addr_o;
    logic [4:0] loc_start_i = '0;
    logic [4:0] loc_end_i = '0;
    logic       buf_rd_o;
    logic [4:0] buf_addr_o;
    logic [7:0] buf_data_i = '0;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       byte_ready_i = 1'b1;
    logic       sof_o;
    logic       eof_o;
    logic       busy_o;

    int vectors = 0;
    int miscompares = 0;
    int overlap = 0;

    logic [4:0] tbl_start [32];
    logic [4:0] tbl_end   [32];
    logic [7:0] mem       [32];
    logic [4:0] loc_q [$];
    logic [4:0] buf_q [$];

    always #5 clk = ~clk;

    message_loc_reader dut (
        .clk          (clk),
        .rst          (rst),
        .wr_count_i   (wr_count_i),
        .rd_count_o   (rd_count_o),
        .loc_rd_o     (loc_rd_o),
        .loc_addr_o   (loc_addr_o),
        .loc_start_i  (loc_start_i),
        .loc_end_i    (loc_end_i),
        .buf_rd_o     (buf_rd_o),
        .buf_addr_o   (buf_addr_o),
        .buf_data_i   (buf_data_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .sof_o        (sof_o),
        .eof_o        (eof_o),
        .busy_o       (busy_o)
    );

    // Synchronous-read models of location table and message buffer.
    always @(posedge clk) begin
        if (loc_rd_o) begin
            loc_start_i <= tbl_start[loc_addr_o];
            loc_end_i   <= tbl_end[loc_addr_o];
        end
        if (buf_rd_o) buf_data_i <= mem[buf_addr_o];
    end

    // Record read addresses and strobe overlap.
    always @(negedge clk) begin
        if (loc_rd_o && buf_rd_o) overlap++;
        if (loc_rd_o) loc_q.push_back(loc_addr_o);
        if (buf_rd_o) buf_q.push_back(buf_addr_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic recv(input string tag, input logic [7:0] eb, input logic es, input logic ee);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (byte_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_valid"}, 32'(ok), 32'd1);
        check({tag, "_byte"}, 32'(byte_o), 32'(eb));
        check({tag, "_sof"}, 32'(sof_o), 32'(es));
        check({tag, "_eof"}, 32'(eof_o), 32'(ee));
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            tbl_start[i] = 5'd9;
            tbl_end[i]   = 5'd9;
            mem[i]       = 8'h00;
        end
        tbl_start[0] = 5'd3;  tbl_end[0] = 5'd6;
        tbl_start[1] = 5'd3;  tbl_end[1] = 5'd6;
        tbl_start[2] = 5'd30; tbl_end[2] = 5'd1;
        tbl_start[3] = 5'd9;  tbl_end[3] = 5'd9;
        tbl_start[31] = 5'd12; tbl_end[31] = 5'd13;
        mem[3] = 8'h41; mem[4] = 8'h42; mem[5] = 8'h43; mem[6] = 8'h44;
        mem[30] = 8'h51; mem[31] = 8'h52; mem[0] = 8'h53; mem[1] = 8'h54;
        mem[9] = 8'h60; mem[12] = 8'h71; mem[13] = 8'h72;

        // Reset state
        idle_wait(3);
        check("rst_valid", 32'(byte_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rdcnt", 32'(rd_count_o), 32'd0);
        check("rst_locrd", 32'(loc_rd_o), 32'd0);
        check("rst_bufrd", 32'(buf_rd_o), 32'd0);
        rst = 1'b1;
        idle_wait(3);
        check("idle_busy", 32'(busy_o), 32'd0);

        // Single message, index 0
        loc_q.delete();
        wr_count_i = 5'd1;
        recv("m0b0", 8'h41, 1'b1, 1'b0);
        recv("m0b1", 8'h42, 1'b0, 1'b0);
        recv("m0b2", 8'h43, 1'b0, 1'b0);
        recv("m0b3", 8'h44, 1'b0, 1'b1);
        idle_wait(3);
        check("m0_rdcnt", 32'(rd_count_o), 32'd1);
        check("m0_busy", 32'(busy_o), 32'd0);
        check("m0_locn", 32'(loc_q.size()), 32'd1);
        check("m0_locaddr", 32'(loc_q[0]), 32'd0);

        // Backpressure on the second byte
        wr_count_i = 5'd2;
        recv("bp_b0", 8'h41, 1'b1, 1'b0);
        @(negedge clk);
        byte_ready_i = 1'b0;
        recv("bp_b1", 8'h42, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_byte", 32'(byte_o), 32'h42);
            check("bp_hold_valid", 32'(byte_valid_o), 32'd1);
            check("bp_hold_bufrd", 32'(buf_rd_o), 32'd0);
        end
        byte_ready_i = 1'b1;
        recv("bp_b2", 8'h43, 1'b0, 1'b0);
        recv("bp_b3", 8'h44, 1'b0, 1'b1);
        idle_wait(3);
        check("bp_rdcnt", 32'(rd_count_o), 32'd2);

        // Wrap across the top of the buffer
        buf_q.delete();
        wr_count_i = 5'd3;
        recv("wr_b0", 8'h51, 1'b1, 1'b0);
        recv("wr_b1", 8'h52, 1'b0, 1'b0);
        recv("wr_b2", 8'h53, 1'b0, 1'b0);
        recv("wr_b3", 8'h54, 1'b0, 1'b1);
        idle_wait(3);
        check("wr_nreads", 32'(buf_q.size()), 32'd4);
        if (buf_q.size() == 4) begin
            check("wr_addr0", 32'(buf_q[0]), 32'd30);
            check("wr_addr1", 32'(buf_q[1]), 32'd31);
            check("wr_addr2", 32'(buf_q[2]), 32'd0);
            check("wr_addr3", 32'(buf_q[3]), 32'd1);
        end
        check("wr_rdcnt", 32'(rd_count_o), 32'd3);

        // One-byte message
        wr_count_i = 5'd4;
        recv("one_b0", 8'h60, 1'b1, 1'b1);
        idle_wait(3);
        check("one_rdcnt", 32'(rd_count_o), 32'd4);

        // Drain indices 4..30 (one-byte fillers) to reach rd_count 31
        wr_count_i = 5'd31;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rd_count_o == 5'd31 && !busy_o) break;
        end
        check("fill_rdcnt", 32'(rd_count_o), 32'd31);

        // Count wrap: indices 31 then 0
        loc_q.delete();
        wr_count_i = 5'd1;
        recv("cw_m31b0", 8'h71, 1'b1, 1'b0);
        recv("cw_m31b1", 8'h72, 1'b0, 1'b1);
        recv("cw_m0b0", 8'h41, 1'b1, 1'b0);
        recv("cw_m0b1", 8'h42, 1'b0, 1'b0);
        recv("cw_m0b2", 8'h43, 1'b0, 1'b0);
        recv("cw_m0b3", 8'h44, 1'b0, 1'b1);
        idle_wait(5);
        check("cw_rdcnt", 32'(rd_count_o), 32'd1);
        check("cw_busy", 32'(busy_o), 32'd0);
        check("cw_locn", 32'(loc_q.size()), 32'd2);
        if (loc_q.size() == 2) begin
            check("cw_loc0", 32'(loc_q[0]), 32'd31);
            check("cw_loc1", 32'(loc_q[1]), 32'd0);
        end

        // Async reset while in SEND
        byte_ready_i = 1'b0;
        wr_count_i = 5'd2;
        recv("ar_b0", 8'h41, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("ar_valid", 32'(byte_valid_o), 32'd0);
        check("ar_sof", 32'(sof_o), 32'd0);
        check("ar_byte", 32'(byte_o), 32'd0);
        check("ar_busy", 32'(busy_o), 32'd0);
        check("ar_rdcnt", 32'(rd_count_o), 32'd0);
        wr_count_i = 5'd1;
        @(negedge clk);
        loc_q.delete();
        rst = 1'b1;
        byte_ready_i = 1'b1;
        recv("ar_m0b0", 8'h41, 1'b1, 1'b0);
        recv("ar_m0b1", 8'h42, 1'b0, 1'b0);
        recv("ar_m0b2", 8'h43, 1'b0, 1'b0);
        recv("ar_m0b3", 8'h44, 1'b0, 1'b1);
        idle_wait(3);
        check("ar_rdcnt_after", 32'(rd_count_o), 32'd1);
        check("ar_locaddr", 32'(loc_q.size() > 0 ? loc_q[0] : 5'h1f), 32'd0);

        check("strobe_overlap", 32'(overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
